wide_word_packer: RTL and testbench

Parametrised narrow-to-wide packer for the DDR3 write path. It collects NUM_WORDS consecutive IN_W-bit words from the UART receive side into one NUM_WORDS*IN_W-bit beat for the memory controller. Successor to the fixed 8x32 collector, adding:
- valid/ready handshakes on both sides
- selectable word ordering
- partial-frame flush with a word count
- backpressure-safe double buffering

---
 rtl/wide_word_packer_if.sv | 27 ++
 rtl/wide_word_packer.sv | 136 +++++++++++++
 tb/tb_wide_word_packer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wide_word_packer_if.sv
// Handshake bundle for the narrow-to-wide packer: word input side, flush
// request and the wide beat output side.
interface wide_word_packer_if #(
    parameter int IN_W      = 32,
    parameter int NUM_WORDS = 8,
    parameter int CNT_W     = $clog2(NUM_WORDS + 1)
);
    logic [IN_W-1:0]           in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic                      flush;
    logic [IN_W*NUM_WORDS-1:0] out_data;
    logic [CNT_W-1:0]          out_words;
    logic                      out_valid;
    logic                      out_ready;
    logic                      busy;

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_data, out_words, out_valid, busy
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_data, out_words, out_valid, busy
    );
endinterface

// File: rtl/wide_word_packer.sv
// Collects NUM_WORDS narrow words into one wide beat with a separate output
// holding register, so collection of the next frame overlaps the held beat.
module wide_word_packer #(
    parameter int              IN_W      = 32,
    parameter int              NUM_WORDS = 8,
    parameter bit              MSB_FIRST = 1'b1,
    parameter logic [IN_W-1:0] PAD       = '0,
    parameter int              CNT_W     = $clog2(NUM_WORDS + 1)
) (
    input logic               clk,
    input logic               rst,
    wide_word_packer_if.slave bus
);
    localparam int                IDX_W    = $clog2(NUM_WORDS);
    localparam int                BEAT_W   = IN_W * NUM_WORDS;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [IN_W-1:0]   collect_r [NUM_WORDS];
    logic [IDX_W-1:0]  idx_r;
    logic              flush_pend_r;
    logic [BEAT_W-1:0] out_data_r;
    logic [CNT_W-1:0]  out_words_r;
    logic              out_valid_r;

    logic [IN_W-1:0]   collect_s [NUM_WORDS];
    logic [IDX_W-1:0]  idx_s;
    logic              flush_pend_s;
    logic [BEAT_W-1:0] out_data_s;
    logic [CNT_W-1:0]  out_words_s;
    logic              out_valid_s;

    logic              in_ready_s;
    logic              accept_s;
    logic              full_s;
    logic              out_free_s;
    logic              flush_go_s;
    logic              flush_set_s;
    logic [BEAT_W-1:0] frame_s;

    // Lowest bit of slot k inside the beat for the selected word ordering.
    function automatic int slot_lo(input int k);
        return MSB_FIRST ? (NUM_WORDS - 1 - k) * IN_W : k * IN_W;
    endfunction

    // Stall terms use only registered state so out_ready never reaches in_ready.
    assign in_ready_s  = rst & ~flush_pend_r & ~((idx_r == LAST_IDX) & out_valid_r);
    assign accept_s    = bus.in_valid & in_ready_s;
    assign full_s      = accept_s & (idx_r == LAST_IDX);
    assign out_free_s  = ~out_valid_r | bus.out_ready;
    assign flush_go_s  = flush_pend_r & out_free_s;
    assign flush_set_s = bus.flush & ~full_s & ((idx_r != '0) | accept_s);

    // Assemble the outgoing frame: stored words, the completing word, then PAD.
    always_comb begin
        frame_s = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (k < int'(idx_r)) begin
                frame_s[slot_lo(k) +: IN_W] = collect_r[k];
            end else if (full_s && (k == NUM_WORDS - 1)) begin
                frame_s[slot_lo(k) +: IN_W] = bus.in_data;
            end else begin
                frame_s[slot_lo(k) +: IN_W] = PAD;
            end
        end
    end

    // Next-state for collection index, flush request and output register.
    always_comb begin
        collect_s    = collect_r;
        idx_s        = idx_r;
        flush_pend_s = flush_pend_r;
        out_data_s   = out_data_r;
        out_words_s  = out_words_r;
        out_valid_s  = out_valid_r;

        if (out_valid_r && bus.out_ready) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end

        if (accept_s) begin
            collect_s[idx_r] = bus.in_data;
            idx_s            = full_s ? '0 : idx_r + IDX_W'(1);
        end else begin
            idx_s = idx_r;
        end

        // A flush only runs while input is stalled, so it never meets an accept.
        if (full_s) begin
            out_data_s  = frame_s;
            out_words_s = CNT_W'(NUM_WORDS);
            out_valid_s = 1'b1;
        end else if (flush_go_s) begin
            out_data_s   = frame_s;
            out_words_s  = CNT_W'(idx_r);
            out_valid_s  = 1'b1;
            idx_s        = '0;
            flush_pend_s = 1'b0;
            for (int k = 0; k < NUM_WORDS; k++) begin
                collect_s[k] = PAD;
            end
        end else if (flush_set_s) begin
            flush_pend_s = 1'b1;
        end else begin
            flush_pend_s = flush_pend_r;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                collect_r[k] <= PAD;
            end
            idx_r        <= '0;
            flush_pend_r <= 1'b0;
            out_data_r   <= {NUM_WORDS{PAD}};
            out_words_r  <= '0;
            out_valid_r  <= 1'b0;
        end else begin
            collect_r    <= collect_s;
            idx_r        <= idx_s;
            flush_pend_r <= flush_pend_s;
            out_data_r   <= out_data_s;
            out_words_r  <= out_words_s;
            out_valid_r  <= out_valid_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_words = out_words_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = (idx_r != '0) | flush_pend_r;
endmodule

// File: tb/tb_wide_word_packer.sv
// Bench for wide_word_packer: two instances (MSB-first/zero PAD and
// LSB-first/0xDEADBEEF PAD) share stimulus; a frame-level model feeds a scoreboard.
module tb_wide_word_packer;
    localparam int          IN_W = 32;
    localparam int          N    = 8;
    localparam logic [31:0] PAD1 = 32'hDEADBEEF;
    typedef logic [IN_W*N-1:0] beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    wide_word_packer_if #(.IN_W(IN_W), .NUM_WORDS(N)) if0 ();
    wide_word_packer_if #(.IN_W(IN_W), .NUM_WORDS(N)) if1 ();

    assign if0.in_data   = in_data;
    assign if0.in_valid  = in_valid;
    assign if0.flush     = flush;
    assign if0.out_ready = out_ready;
    assign if1.in_data   = in_data;
    assign if1.in_valid  = in_valid;
    assign if1.flush     = flush;
    assign if1.out_ready = out_ready;

    wide_word_packer #(.IN_W(IN_W), .NUM_WORDS(N), .MSB_FIRST(1'b1), .PAD(32'h0))
        u_msb (.clk(clk), .rst(rst), .bus(if0.slave));
    wide_word_packer #(.IN_W(IN_W), .NUM_WORDS(N), .MSB_FIRST(1'b0), .PAD(PAD1))
        u_lsb (.clk(clk), .rst(rst), .bus(if1.slave));

    int errors = 0;
    int checks = 0;
    int beats_seen = 0;
    int stalls = 0;

    logic [31:0] cur[$];
    beat_t       exp0_q[$];
    beat_t       exp1_q[$];
    int          expw_q[$];

    task automatic chk(input string name, input beat_t act, input beat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the frame so far is cur[0..cnt-1], remaining slots are PAD.
    task automatic push_exp(input int cnt);
        beat_t e0 = '0;
        beat_t e1 = '0;
        logic [31:0] w0, w1;
        for (int k = 0; k < N; k++) begin
            w0 = (k < cnt) ? cur[k] : 32'h0;
            w1 = (k < cnt) ? cur[k] : PAD1;
            e0 = (e0 << IN_W) | beat_t'(w0);
            e1 = e1 | (beat_t'(w1) << (IN_W * k));
        end
        exp0_q.push_back(e0);
        exp1_q.push_back(e1);
        expw_q.push_back(cnt);
        cur.delete();
    endtask

    // One cycle of stimulus; in_ready depends only on state, so it is read first.
    task automatic drive(input logic v, input logic [31:0] d, input logic f, output logic acc);
        logic done;
        logic fe;
        @(negedge clk);
        acc  = v & if0.in_ready;
        done = 1'b0;
        if (acc) begin
            cur.push_back(d);
            if (cur.size() == N) begin
                push_exp(N);
                done = 1'b1;
            end
        end
        fe = f & (!v | acc);
        if (fe && !done && cur.size() > 0) push_exp(cur.size());
        in_valid = v;
        in_data  = d;
        flush    = fe;
    endtask

    task automatic send_word(input logic [31:0] d, input logic f);
        logic acc;
        int tries = 0;
        do begin
            drive(1'b1, d, f, acc);
            tries++;
        end while (!acc && tries < 64);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept within 64 cycles");
        end
        stalls += tries - 1;
    endtask

    task automatic idle();
        logic a;
        drive(1'b0, 32'h0, 1'b0, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        cur.delete();
        exp0_q.delete();
        exp1_q.delete();
        expw_q.delete();
        @(negedge clk);
        #1;
        chk("rst_in_ready", beat_t'(if0.in_ready), beat_t'(0));
        chk("rst_out_valid", beat_t'(if0.out_valid), beat_t'(0));
        chk("rst_out_valid_lsb", beat_t'(if1.out_valid), beat_t'(0));
        chk("rst_busy", beat_t'(if0.busy), beat_t'(0));
        chk("rst_out_words", beat_t'(if0.out_words), beat_t'(0));
        chk("rst_out_data", if0.out_data, beat_t'(0));
        chk("rst_out_data_pad", if1.out_data, beat_t'({N{PAD1}}));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", beat_t'(if0.in_ready), beat_t'(1));
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((exp0_q.size() != 0) && n < 200) begin
            idle();
            n++;
        end
        repeat (3) idle();
        chk("drained", beat_t'(exp0_q.size()), beat_t'(0));
    endtask

    // Monitor: pops the scoreboard on each output handshake, checks hold stability.
    initial begin
        beat_t held = '0;
        logic  held_v = 1'b0;
        beat_t e0, e1;
        int    ew;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                held_v = 1'b0;
            end else if (if0.out_valid) begin
                if (held_v) chk("hold_stable", if0.out_data, held);
                chk("words_range", beat_t'(if0.out_words >= 1 && if0.out_words <= N), beat_t'(1));
                chk("lsb_valid", beat_t'(if1.out_valid), beat_t'(1));
                if (out_ready) begin
                    beats_seen++;
                    held_v = 1'b0;
                    if (exp0_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %h expected no beat", if0.out_data);
                    end else begin
                        e0 = exp0_q.pop_front();
                        e1 = exp1_q.pop_front();
                        ew = expw_q.pop_front();
                        chk("beat_msb", if0.out_data, e0);
                        chk("beat_lsb", if1.out_data, e1);
                        chk("beat_words", beat_t'(if0.out_words), beat_t'(ew));
                        chk("beat_words_lsb", beat_t'(if1.out_words), beat_t'(ew));
                    end
                end else begin
                    held   = if0.out_data;
                    held_v = 1'b1;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    s0, b0;
        logic  acc;
        logic  pend;
        logic [31:0] d;
        logic  v;

        do_reset();

        // Test 1: eight words, consumer always ready.
        out_ready = 1'b1;
        s0 = stalls;
        for (int i = 1; i <= 8; i++) send_word(32'(i), 1'b0);
        idle();
        #1;
        chk("t1_latency_valid", beat_t'(if0.out_valid), beat_t'(1));
        chk("t1_words", beat_t'(if0.out_words), beat_t'(8));
        chk("t1_data_msb", if0.out_data,
            256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
        chk("t1_data_lsb", if1.out_data,
            256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        chk("t1_no_stall", beat_t'(stalls), beat_t'(s0));

        // Test 2: sixteen words stream with no input stall.
        s0 = stalls;
        for (int i = 0; i < 16; i++) send_word($urandom, 1'b0);
        chk("t2_no_stall", beat_t'(stalls), beat_t'(s0));
        drain();

        // Test 3: backpressure holds the first beat and stalls the 16th word.
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) send_word(32'h100 + 32'(i), 1'b0);
        repeat (3) begin
            idle();
            #1;
            chk("t3_stall_ready", beat_t'(if0.in_ready), beat_t'(0));
        end
        out_ready = 1'b1;
        send_word(32'h10F, 1'b0);
        drain();

        // Test 4: partial frame flush.
        send_word(32'hA, 1'b0);
        send_word(32'hB, 1'b0);
        send_word(32'hC, 1'b0);
        drive(1'b0, 32'h0, 1'b1, acc);
        idle();
        #1;
        chk("t4_busy_pend", beat_t'(if0.busy), beat_t'(1));
        idle();
        #1;
        chk("t4_busy_clear", beat_t'(if0.busy), beat_t'(0));
        chk("t4_words", beat_t'(if0.out_words), beat_t'(3));
        chk("t4_data_msb", if0.out_data,
            256'h0000000A_0000000B_0000000C_00000000_00000000_00000000_00000000_00000000);
        chk("t4_data_lsb", if1.out_data,
            256'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF_0000000C_0000000B_0000000A);
        drain();

        // Test 5: flush with the completing word, then flush while empty.
        b0 = beats_seen;
        for (int i = 0; i < 7; i++) send_word(32'h200 + 32'(i), 1'b0);
        send_word(32'h207, 1'b1);
        repeat (2) idle();
        drive(1'b0, 32'h0, 1'b1, acc);
        repeat (4) idle();
        #1;
        chk("t5_one_beat", beat_t'(beats_seen - b0), beat_t'(1));
        chk("t5_busy", beat_t'(if0.busy), beat_t'(0));
        drain();

        // Test 6: reset with a held beat and a partial frame discards both.
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++) send_word(32'h300 + 32'(i), 1'b0);
        do_reset();
        out_ready = 1'b1;
        b0 = beats_seen;
        for (int i = 0; i < 8; i++) send_word(32'h400 + 32'(i), 1'b0);
        drain();
        chk("t6_one_beat", beat_t'(beats_seen - b0), beat_t'(1));

        // Random traffic: gaps, backpressure and occasional flushes.
        pend = 1'b0;
        d    = 32'h0;
        for (int i = 0; i < 1500; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            v = pend | ($urandom_range(0, 3) != 0);
            if (!pend) d = $urandom;
            drive(v, d, ($urandom_range(0, 15) == 0), acc);
            pend = v & !acc;
        end
        while (pend) begin
            drive(1'b1, d, 1'b0, acc);
            pend = !acc;
        end
        drive(1'b0, 32'h0, 1'b1, acc);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
